// File: rtl/pwm_capture.sv
// PWM period/high-time/duty capture with stuck-input detection.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [3:0]       duty_tenths,
    output logic             meas_valid,
    output logic             stuck
);

    localparam int RW = CNT_W + 4;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntSatPrev = CntMax - CntOne;

    localparam logic [1:0] StArm  = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StCalc = 2'd2;

    logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hreg_q, hreg_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [3:0]       quo_q, quo_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [3:0]       duty_q, duty_d;
    logic             valid_q, valid_d, stuck_q, stuck_d;

    logic             level, rise, fall, sat;
    logic [RW-1:0]    hreg_ext, per_ext;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;

    // Level follows the synchronizer only once three consecutive samples agree.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        level   = filt_q;
        if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
            level = sync2_q;
        end
        filt_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d  = pwm_in;
        sync2_d  = sync1_q;
        prev_d   = level;
        rise     = level & ~prev_q;
        fall     = ~level & prev_q;
        hreg_ext = {4'b0000, hreg_q};
        per_ext  = {4'b0000, per_q};

        cnt_d  = rise ? CntOne : ((cnt_q == CntMax) ? cnt_q : cnt_q + CntOne);
        hreg_d = fall ? cnt_q : hreg_q;
        // Fires only in the cycle the counter first reaches its maximum.
        sat    = ~rise && (cnt_q == CntSatPrev) && (state_q != StCalc);

        state_d  = state_q;
        per_d    = per_q;
        hi_d     = hi_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        period_d = period_q;
        high_d   = high_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;

        case (state_q)
            StArm, StRun: begin
                if (rise) begin
                    state_d = StRun;
                    if (state_q == StRun) begin
                        per_d   = cnt_q;
                        hi_d    = hreg_q;
                        rem_d   = (hreg_ext << 3) + (hreg_ext << 1);
                        quo_d   = 4'd0;
                        state_d = StCalc;
                    end
                end else if (sat) begin
                    stuck_d  = 1'b1;
                    period_d = '0;
                    high_d   = '0;
                    duty_d   = level ? 4'd10 : 4'd0;
                    valid_d  = 1'b1;
                    state_d  = StArm;
                end
            end
            StCalc: begin
                // Quotient capped at 10 so a stale high register clamps the duty.
                if ((rem_q >= per_ext) && (quo_q < 4'd10)) begin
                    rem_d = rem_q - per_ext;
                    quo_d = quo_q + 4'd1;
                end else begin
                    period_d = per_q;
                    high_d   = hi_q;
                    duty_d   = quo_q;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b0;
                    state_d  = StRun;
                end
            end
            default: state_d = StArm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            hreg_q   <= '0;
            state_q  <= StArm;
            per_q    <= '0;
            hi_q     <= '0;
            rem_q    <= '0;
            quo_q    <= 4'd0;
            period_q <= '0;
            high_q   <= '0;
            duty_q   <= 4'd0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            hreg_q   <= hreg_d;
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            period_q <= period_d;
            high_q   <= high_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign period_cnt  = period_q;
    assign high_cnt    = high_q;
    assign duty_tenths = duty_q;
    assign meas_valid  = valid_q;
    assign stuck       = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected measurements are queued as the waveform is
// driven and popped on each meas_valid pulse.
module tb_pwm_capture;

    localparam int W = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int H7 = 3;
`else
    localparam int H7 = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         pwm_in;
    logic [W-1:0] period_cnt, high_cnt;
    logic [3:0]   duty_tenths;
    logic         meas_valid, stuck;

    typedef struct {
        int p;
        int h;
        int d;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .duty_tenths(duty_tenths),
        .meas_valid (meas_valid),
        .stuck      (stuck)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic void push(input int p, input int h);
        exp_t e;
        e.p = p;
        e.h = h;
        e.d = (h * 10) / p;
        if (e.d > 10) e.d = 10;
        e.s = 0;
        exp_q.push_back(e);
    endfunction

    function automatic void push_stuck(input int d);
        exp_t e;
        e.p = 0;
        e.h = 0;
        e.d = d;
        e.s = 1;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (meas_valid === 1'b1) begin
            chk("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("period_cnt", period_cnt, e.p);
                chk("high_cnt", high_cnt, e.h);
                chk("duty_tenths", duty_tenths, e.d);
                chk("stuck_at_valid", stuck, e.s);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic train(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            cyc(h);
            pwm_in = 1'b0;
            cyc(p - h);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"}, period_cnt, 0);
        chk({tag, "_high"}, high_cnt, 0);
        chk({tag, "_duty"}, duty_tenths, 0);
        chk({tag, "_valid"}, meas_valid, 0);
        chk({tag, "_stuck"}, stuck, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        cyc(3);
        check_zero("reset");
        rst = 1'b0;

        // 10/5 repeated: first rise only arms.
        for (int i = 0; i < 3; i++) push(10, 5);
        train(10, 5, 4);
        cyc(20);
        chk("drained_10_5", exp_q.size(), 0);
        do_reset();

        // Mixed periods, including 7-cycle period.
        push(10, 5);
        push(10, 5);
        push(7, H7);
        push(7, H7);
        train(10, 5, 2);
        train(7, H7, 3);
        cyc(20);
        chk("drained_mixed", exp_q.size(), 0);
        do_reset();

        // Duty near 9 and 0.
        for (int i = 0; i < 3; i++) push(40, 37);
        push(31, 3);
        push(31, 3);
        train(40, 37, 3);
        train(31, 3, 3);
        cyc(20);
        chk("drained_edges", exp_q.size(), 0);
        do_reset();

        // Reset in the middle of a division: no measurement, then re-arm.
        train(10, 7, 1);
        pwm_in = 1'b1;
        cyc(6);
        rst = 1'b1;
        cyc(1);
        rst    = 1'b0;
        pwm_in = 1'b0;
        check_zero("calc_abort");
        cyc(5);
        push(10, 5);
        push(10, 5);
        train(10, 5, 3);
        cyc(20);
        chk("drained_after_abort", exp_q.size(), 0);
        do_reset();

        // Input stuck high after one rising edge.
        pwm_in = 1'b1;
        push_stuck(10);
        cyc(300);
        chk("stuck_set", stuck, 1);
        chk("stuck_duty", duty_tenths, 10);
        chk("stuck_period", period_cnt, 0);
        chk("drained_stuck", exp_q.size(), 0);
        pwm_in = 1'b0;
        cyc(5);
        push(10, 5);
        train(10, 5, 2);
        cyc(20);
        chk("stuck_cleared", stuck, 0);
        chk("drained_recover", exp_q.size(), 0);
        do_reset();

        // One-cycle low glitch inside the high phase.
        pwm_in = 1'b0;
        cyc(3);
        push(10, 5);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        push(10, 5);
`else
        push(7, 2);
`endif
        train(10, 5, 1);
        pwm_in = 1'b1;
        cyc(2);
        pwm_in = 1'b0;
        cyc(1);
        pwm_in = 1'b1;
        cyc(2);
        pwm_in = 1'b0;
        cyc(5);
        pwm_in = 1'b1;
        cyc(3);
        pwm_in = 1'b0;
        cyc(20);
        chk("drained_glitch", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the cycle counters and measurement outputs (minimum 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pwm_in  input  1  PWM waveform, asynchronous to clk.
REQ-005 SHALL have port period_cnt  output  CNT_W  last measured period in clk cycles.
REQ-006 SHALL have port high_cnt  output  CNT_W  last measured high time in clk cycles.
REQ-007 SHALL have port duty_tenths  output  4  last duty cycle in tenths, range 0..10.
REQ-008 SHALL have port meas_valid  output  1  one-cycle pulse when the outputs update.
REQ-009 SHALL have port stuck  output  1  level: no rising edge seen within the timeout.

Function
REQ-010 SHALL pass pwm_in through a 2-flop synchronizer; edge detection SHALL compare the synchronized level with its one-cycle-delayed copy.
REQ-011 SHALL run a free cycle counter that loads 1 on each detected rising edge and otherwise increments, saturating at 2^CNT_W-1.
REQ-012 SHALL capture the counter value into an internal high register on each detected falling edge.
REQ-013 SHALL implement FSM states ARM, RUN, CALC; reset state is ARM.
REQ-014 ARM: the first rising edge moves the FSM to RUN; no measurement is produced.
REQ-015 RUN: a rising edge latches period = counter value and high = internal high register, then enters CALC.
REQ-016 CALC: SHALL compute duty_tenths = floor(high*10/period) by repeated subtraction of period from a (CNT_W+4)-bit remainder, one subtraction per cycle, at most 11 cycles.
REQ-017 On CALC completion, period_cnt, high_cnt and duty_tenths SHALL update in the same cycle, meas_valid SHALL pulse for one cycle, stuck SHALL clear, and the FSM SHALL return to RUN.
REQ-018 A rising edge arriving during CALC SHALL restart the counter but SHALL NOT start a new measurement; that period is dropped.
REQ-019 If the counter saturates in RUN or ARM: stuck=1, period_cnt=0, high_cnt=0, duty_tenths=10 if the synchronized level is 1, else 0; meas_valid pulses once; FSM goes to ARM.
REQ-020 A rising edge in the same cycle as saturation SHALL take priority; saturation handling is skipped.
REQ-021 high > period cannot occur; if the internal high register is stale (no falling edge in the period), duty_tenths SHALL clamp to 10.

Reset
REQ-022 On rst=1 at a clk edge, period_cnt, high_cnt, duty_tenths, meas_valid, stuck, the counter, the high register and the synchronizer flops SHALL all go to 0, and the FSM SHALL go to ARM.
REQ-023 Reset asserted during CALC SHALL abort the division with no meas_valid pulse.

Configuration
REQ-024 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: the synchronized level SHALL change only after 3 consecutive equal samples, adding 2 cycles of latency; pulses of 1-2 cycles are ignored.
REQ-025 Macro undefined: no filter; the 2-flop synchronizer output feeds edge detection directly.

Verification
REQ-026 Period 10, high 5, repeated -> second and later meas_valid give period_cnt=10, high_cnt=5, duty_tenths=5.
REQ-027 Period 7, high 2 -> period_cnt=7, high_cnt=2, duty_tenths=2 (floor of 20/7).
REQ-028 pwm_in held at 1 after one rising edge, CNT_W=8 -> after 255 cycles stuck=1, duty_tenths=10, single meas_valid pulse; next valid period clears stuck.
REQ-029 rst pulsed during CALC -> no meas_valid; all outputs 0; the first following rising edge only arms the FSM.
REQ-030 Macro defined, period 10/high 5 with a 1-cycle low glitch inside the high phase -> measurement unchanged at 10/5/5; macro undefined -> that period is split and measured as a shorter period.
